// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared types and helpers for the neural-network layer blocks:
//               scheduler state encoding, activation width, accumulator
//               sizing and the requantise/ReLU/clamp output function.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int ACT_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BIAS = 3'd1,
        MAC  = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_t;

    // A 16-bit product summed n_in times, plus one bit of headroom for the bias.
    function automatic int acc_width(input int n_in);
        return 16 + $clog2(n_in) + 1;
    endfunction

    // Arithmetic shift, then ReLU at 0 and saturate at 127.
    function automatic logic [ACT_W-1:0] relu_clamp8(input logic signed [63:0] acc,
                                                     input int                 shift);
        logic signed [63:0] r;
        r = acc >>> shift;
        if (r < 64'sd0) begin
            return '0;
        end else if (r > 64'sd127) begin
            return 8'd127;
        end else begin
            return r[ACT_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_mac_scheduler_mac.sv
`default_nettype none
// ============================================================================
// Module      : mac_acc_unit
// Description : Shared signed 8x8 multiply-accumulate. The first product of a
//               neuron is added to the sign-extended bias; later products are
//               added to the running sum. On the last product the requantised
//               and clamped result is captured in the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_acc_unit
    import nn_pkg::*;
#(
    parameter int ACC_W = 21,
    parameter int SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_first,
    input  logic                    i_last,
    input  logic signed [ACT_W-1:0] i_act,
    input  logic signed [ACT_W-1:0] i_w,
    input  logic signed [ACT_W-1:0] i_bias,
    output logic        [ACT_W-1:0] o_data
);

    logic signed [15:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_next;
    logic signed [ACC_W-1:0] r_acc;
    logic        [ACT_W-1:0] r_out;

    assign w_prod     = i_act * i_w;
    assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-ACT_W){i_bias[ACT_W-1]}}, i_bias};
    // The bias enters at the pre-shift scale, so it is simply the seed of the sum.
    assign w_base     = i_first ? w_bias_ext : r_acc;
    assign w_next     = w_base + w_prod_ext;

    // Accumulate every MAC cycle; capture the clamped result on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (i_en) begin
            r_acc <= w_next;
            if (i_last) begin
                r_out <= relu_clamp8({{(64-ACC_W){w_next[ACC_W-1]}}, w_next}, SHIFT);
            end
        end
    end

    assign o_data = r_out;

endmodule
`default_nettype wire

// File: rtl/layer_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : layer_mac_scheduler
// Description : Fully-connected layer on one shared MAC. Walks N_OUT neurons,
//               each as BIAS (issue addresses), N_IN MAC cycles and one WB
//               cycle that strobes the 8-bit result. The weight address is a
//               running counter that spans all neurons contiguously.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_mac_scheduler
    import nn_pkg::*;
#(
    parameter int N_IN  = 15,
    parameter int N_OUT = 16,
    parameter int SHIFT = 0,
    localparam int c_ACT_AW = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int c_W_AW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int c_B_AW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [c_ACT_AW-1:0]     act_addr,
    input  logic signed [ACT_W-1:0] act_data,
    output logic [c_W_AW-1:0]       w_addr,
    input  logic signed [ACT_W-1:0] w_data,
    output logic [c_B_AW-1:0]       b_addr,
    input  logic signed [ACT_W-1:0] b_data,
    output logic                    out_valid,
    output logic [c_B_AW-1:0]       out_idx,
    output logic [ACT_W-1:0]        out_data,
    output logic                    busy,
    output logic                    done
);

    localparam int              c_ACC_W  = acc_width(N_IN);
    localparam logic [2:0]      c_S_IDLE = IDLE;
    localparam logic [2:0]      c_S_BIAS = BIAS;
    localparam logic [2:0]      c_S_MAC  = MAC;
    localparam logic [2:0]      c_S_WB   = WB;
    localparam logic [2:0]      c_S_DONE = DONE;
    localparam logic [c_ACT_AW-1:0] c_K_LAST = c_ACT_AW'(N_IN - 1);
    localparam logic [c_B_AW-1:0]   c_J_LAST = c_B_AW'(N_OUT - 1);

    logic [2:0]          r_state;
    logic [c_B_AW-1:0]   r_j;
    logic [c_ACT_AW-1:0] r_k;
    logic [c_ACT_AW-1:0] r_act_addr;
    logic [c_W_AW-1:0]   r_w_addr;
    logic [c_B_AW-1:0]   r_b_addr;
    logic                r_out_valid;
    logic [c_B_AW-1:0]   r_out_idx;
    logic                r_busy;
    logic                r_done;
    logic                w_mac_en;
    logic                w_mac_first;
    logic                w_mac_last;

    assign w_mac_en    = (r_state == c_S_MAC);
    assign w_mac_first = (r_k == '0);
    assign w_mac_last  = (r_k == c_K_LAST);

    // Scheduler: state sequencing, neuron/product counters and read addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_j         <= '0;
            r_k         <= '0;
            r_act_addr  <= '0;
            r_w_addr    <= '0;
            r_b_addr    <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state    <= c_S_BIAS;
                        r_j        <= '0;
                        r_act_addr <= '0;
                        r_w_addr   <= '0;
                        r_b_addr   <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                c_S_BIAS: begin
                    r_state <= c_S_MAC;
                    r_k     <= '0;
                    // Prefetch the second operand pair so data arrives on MAC cycle 1.
                    if (N_IN > 1) begin
                        r_act_addr <= c_ACT_AW'(1);
                        r_w_addr   <= r_w_addr + 1'b1;
                    end
                end
                c_S_MAC: begin
                    if (w_mac_last) begin
                        r_state     <= c_S_WB;
                        r_out_valid <= 1'b1;
                        r_out_idx   <= r_j;
                    end else begin
                        r_k <= r_k + 1'b1;
                        // Stop issuing once the last operand pair is in flight.
                        if (32'(r_k) + 2 < N_IN) begin
                            r_act_addr <= r_act_addr + 1'b1;
                            r_w_addr   <= r_w_addr + 1'b1;
                        end
                    end
                end
                c_S_WB: begin
                    r_out_valid <= 1'b0;
                    if (r_j != c_J_LAST) begin
                        r_state    <= c_S_BIAS;
                        r_j        <= r_j + 1'b1;
                        r_b_addr   <= r_j + 1'b1;
                        r_act_addr <= '0;
                        r_w_addr   <= r_w_addr + 1'b1;
                    end else begin
                        r_state    <= c_S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_act_addr <= '0;
                        r_w_addr   <= '0;
                        r_b_addr   <= '0;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    mac_acc_unit #(
        .ACC_W (c_ACC_W),
        .SHIFT (SHIFT)
    ) u_mac (
        .clk     (clk),
        .rst     (reset),
        .i_en    (w_mac_en),
        .i_first (w_mac_first),
        .i_last  (w_mac_last),
        .i_act   (act_data),
        .i_w     (w_data),
        .i_bias  (b_data),
        .o_data  (out_data)
    );

    assign act_addr  = r_act_addr;
    assign w_addr    = r_w_addr;
    assign b_addr    = r_b_addr;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: doc/layer_mac_scheduler.md
Name: layer_mac_scheduler

Overview:
- Computes one fully-connected layer on a single shared signed 8-bit multiply-accumulate unit: N_OUT neurons, each over N_IN activations.
- Sequences reads from the activation buffer, the weight ROM and the bias ROM, adds bias, applies ReLU and clamp, and emits one 8-bit result per neuron.
- Replaces N_OUT parallel per-neuron MAC nodes in a layer where area matters more than latency.
- Sits between the previous layer's activation buffer and the next layer's input buffer.

Parameters:
- N_IN, 15: activations per neuron.
- N_OUT, 16: neurons in the layer.
- SHIFT, 0: arithmetic right shift applied to the accumulator before ReLU and clamp (requantisation).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to compute the whole layer; ignored unless IDLE
- act_addr  out  clog2(N_IN)  activation buffer read address
- act_data  in  8  signed activation, valid 1 cycle after act_addr
- w_addr  out  clog2(N_IN*N_OUT)  weight ROM address (neuron-major)
- w_data  in  8  signed weight, valid 1 cycle after w_addr
- b_addr  out  clog2(N_OUT)  bias ROM address
- b_data  in  8  signed bias, valid 1 cycle after b_addr
- out_valid  out  1  one-cycle strobe: out_data/out_idx valid
- out_idx  out  clog2(N_OUT)  neuron index of the result
- out_data  out  8  result in 0..127
- busy  out  1  layer computation in progress
- done  out  1  one-cycle pulse after the last neuron

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high, all registers.
- Reset values: all outputs 0 and state IDLE. Reset mid-operation aborts the layer with no further out_valid or done; the next start begins at neuron 0.
- States and transitions:
  - IDLE -> BIAS on start.
  - BIAS -> MAC after 1 cycle.
  - MAC -> WB after N_IN cycles.
  - WB -> BIAS if j < N_OUT-1, else DONE.
  - DONE -> IDLE after 1 cycle.
- BIAS (neuron j): drive b_addr=j, act_addr=0, w_addr=j*N_IN.
- MAC cycle k (0..N_IN-1):
  - Consume returned data: k=0 gives acc = sext(b_data) + act_data*w_data; k>0 gives acc += act_data*w_data.
  - Issue act_addr=k+1 and w_addr=j*N_IN+k+1 while k < N_IN-1.
- w_addr comes from an incrementing counter, not a multiplier. It runs 0..N_IN*N_OUT-1 contiguously across neurons.
- Arithmetic:
  - Each product is a full 16-bit signed value.
  - Accumulator width is ACC_W = 16 + clog2(N_IN) + 1 signed, so it never overflows.
  - Bias is added unshifted, i.e. in pre-shift scale.
- Output computation, on the final MAC edge:
  - r = next_acc >>> SHIFT.
  - out_data = 0 if r < 0, 127 if r > 127, else r[7:0].
  - out_idx = j.
  - out_valid is high exactly during the WB cycle; out_data and out_idx hold until the next WB.
- Timing:
  - One neuron takes N_IN+2 cycles.
  - The start edge is cycle 0. Neuron j's WB falls in cycle (j+1)(N_IN+2).
  - done is high in cycle N_OUT(N_IN+2)+1 (273 at defaults).
  - busy is high from the first BIAS through the last WB inclusive, and low in the done cycle.
- start asserted while busy or in DONE is ignored, not queued.
- Address outputs return to 0 in IDLE.

Decomposition:
- Shared package nn_pkg:
  - state enum {IDLE, BIAS, MAC, WB, DONE}
  - ACT_W=8
  - function acc_width(n_in)
  - function relu_clamp8(acc, shift)
- One sub-module, mac_acc_unit: signed multiply, bias load or accumulate select, and relu_clamp8 output register. The scheduler FSM and address counters stay in the top module.

Test Plan:
- Reset, then idle 10 cycles -> busy=0, done=0, out_valid=0, all addresses 0.
- Defaults, act=2, w=3, bias=4 -> 16 out_valid strobes 17 cycles apart, out_idx 0..15, out_data=94 each; done in cycle 273; w_addr for neuron 1 runs 15..29.
- act=10, w=-5 (0xFB), bias=0 -> acc=-750, out_data=0 for all neurons (ReLU).
- act=127, w=127, bias=127 -> acc=242062, out_data=127 (clamp, no accumulator overflow); act=-128, w=-128 -> acc=245760, out_data=127.
- SHIFT=7, act=16, w=16, bias=0 -> 3840>>>7=30, out_data=30.
- start pulsed again during neuron 3 -> ignored, sequence unchanged. reset during neuron 5 MAC -> next cycle busy=0, no further out_valid or done. New start -> out_idx restarts at 0.
